load_store_unit: RTL

MEM-stage load/store controller that sits directly upstream of the byte-addressed data memory. It accepts one memory request per cycle from the EX/MEM pipeline register and drives the memory's write-enable, read-enable, size, address and write-data inputs. It registers load results into a MEM/WB output and stalls the pipeline while it performs a read-modify-write (RMW). The RMW is needed because the memory's write port always writes 16 bits (address and address+1), so it cannot store a single byte.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 37 +++
 rtl/load_store_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and widths for the MEM-stage load/store path.
package mem_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;

    localparam logic [1:0] MEM_WORD   = 2'b00;
    localparam logic [1:0] MEM_BYTE_U = 2'b01;
    localparam logic [1:0] MEM_BYTE_S = 2'b10;

    typedef enum logic {
        LSU_IDLE,
        LSU_RMW_WRITE
    } lsu_state_t;

    function automatic logic is_byte(input logic [1:0] size);
        return (size == MEM_BYTE_U) || (size == MEM_BYTE_S);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: valid pulses per request, payload holds otherwise.
module mem_wb_reg #(
    parameter int DATA_W    = 16,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_reg_write,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid <= in_valid;
            if (in_valid) begin
                wb_reg_write <= in_reg_write;
            end
            // rd and data only move on loads
            if (in_valid && in_reg_write) begin
                wb_rd   <= in_rd;
                wb_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller; byte stores use a read-modify-write
// because the memory write port always writes a full 16-bit word.
import mem_pkg::*;

module load_store_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [REG_IDX_W-1:0] req_rd,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic [1:0]           mem_num_bytes,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data
);

    lsu_state_t        state, state_nx;
    logic [7:0]        hi_byte, byte_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic              latch_en;
    logic              wb_in_valid, wb_in_reg_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LSU_IDLE;
            hi_byte  <= '0;
            byte_lat <= '0;
            addr_lat <= '0;
        end else begin
            state <= state_nx;
            if (latch_en) begin
                hi_byte  <= mem_rdata[15:8];
                byte_lat <= req_wdata[7:0];
                addr_lat <= req_addr;
            end
        end
    end

    always_comb begin
        state_nx        = state;
        req_ready       = (state == LSU_IDLE);
        mem_wr_en       = 1'b0;
        mem_rd_en       = 1'b0;
        mem_num_bytes   = (req_size == 2'b11) ? MEM_WORD : req_size;
        mem_addr        = req_addr;
        mem_wdata       = req_wdata;
        latch_en        = 1'b0;
        wb_in_valid     = 1'b0;
        wb_in_reg_write = 1'b0;
        if (reset) begin
            state_nx = LSU_IDLE;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid && !req_write) begin
                        mem_rd_en       = 1'b1;
                        wb_in_valid     = 1'b1;
                        wb_in_reg_write = 1'b1;
                    end else if (req_valid && is_byte(req_size)) begin
                        // fetch the neighbour byte so it can be written back
                        mem_rd_en     = 1'b1;
                        mem_num_bytes = MEM_WORD;
                        latch_en      = 1'b1;
                        state_nx      = LSU_RMW_WRITE;
                    end else if (req_valid) begin
                        mem_wr_en   = 1'b1;
                        wb_in_valid = 1'b1;
                    end
                end
                LSU_RMW_WRITE: begin
                    mem_wr_en     = 1'b1;
                    mem_num_bytes = MEM_WORD;
                    mem_addr      = addr_lat;
                    mem_wdata     = {hi_byte, byte_lat};
                    wb_in_valid   = 1'b1;
                    state_nx      = LSU_IDLE;
                end
                default: state_nx = LSU_IDLE;
            endcase
        end
    end

    mem_wb_reg #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (wb_in_valid),
        .in_reg_write (wb_in_reg_write),
        .in_rd        (req_rd),
        .in_data      (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

endmodule
